fp_div_writeback: RTL and testbench
===================================

// Module: fp_div_writeback
// PURPOSE
//  Result-side controller for the fixed-latency, enable-gated FP divider (fp_div). Accepts tagged
//  divide issues, drives the divider's enable, and tracks valid/tag alongside the divider pipeline.
//  Captures each result leaving the pipeline into a small output FIFO.
//  Presents results to writeback through a valid/ready handshake, stalling the divider (never
//  dropping a result) when writeback back-pressures.
// PARAMETERS
//  DATA_WIDTH  32  result width (matches fp_div res)
//  TAG_WIDTH    8  issue tag (destination reg/thread id) carried with each operation
//  LATENCY     15  fp_div depth in enabled clock edges, from operand capture to res valid (>=1)
//  FIFO_DEPTH   4  output FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1           clock
//  rst          in   1           asynchronous reset, active-low
//  flush        in   1           synchronous kill of all in-flight and buffered ops
//  issue_valid  in   1           op0/op1 presented to fp_div this cycle
//  issue_tag    in   TAG_WIDTH   tag of issued op
//  issue_ready  out  1           op accepted when issue_valid && issue_ready
//  div_enable   out  1           drives fp_div enable
//  div_res      in   DATA_WIDTH  fp_div res
//  out_valid    out  1           result available at FIFO head
//  out_data     out  DATA_WIDTH  head result
//  out_tag      out  TAG_WIDTH   head tag
//  out_ready    in   1           writeback pops head when out_valid && out_ready
//  busy         out  1           any op in flight or buffered
// BEHAVIOUR
//  - Reset (rst=0, async): all stage valids=0, FIFO empty; out_valid=0, out_data=0, out_tag=0,
//    busy=0. div_enable and issue_ready are combinational and read 1 when the pipeline is empty.
//    Reset mid-operation discards everything; divider contents after reset are don't-care
//    (their valids are cleared).
//  - Shadow pipe: LATENCY stages of {valid, tag}. It shifts only on edges where div_enable=1.
//    Stage 0 loads {issue_valid, issue_tag}; a bubble is loaded when issue_valid=0.
//  - tail = last stage. When tail.valid=1, div_res is the result for tail.tag in the same cycle.
//  - can_push = (count < FIFO_DEPTH) || (out_valid && out_ready).
//  - div_enable = !tail.valid || can_push. issue_ready = div_enable.
//    With the FIFO full and the tail valid, the whole pipe freezes. Bubbles do not compress.
//  - Push {div_res, tail.tag} into the FIFO when tail.valid && div_enable.
//    Push and pop in the same cycle are allowed when full; count is unchanged.
//  - FIFO output is registered: a push at edge t gives out_valid=1 after t when the FIFO was empty.
//  - Unstalled latency: issue accepted in cycle c -> out_valid in cycle c+LATENCY+1, in issue order.
//  - busy = |stage valids || count != 0.
//  - flush=1: at the next edge clear all stage valids and empty the FIFO.
//    flush has priority over issue, push and pop in that cycle. div_enable is unaffected.
//  - Output stability: while out_valid && !out_ready, out_data/out_tag stay constant.
//  - count is clog2(FIFO_DEPTH)+1 bits. Pointers wrap modulo FIFO_DEPTH.
// TESTING
//  1. Single op, bench instantiates the real fp_div: op0=0x40C00000, op1=0x40000000, tag=0x05
//     -> out_valid in cycle c+16, out_data=0x40400000, out_tag=0x05.
//  2. 8 back-to-back issues, tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles, tags 0..7
//     in order, issue_ready stays 1.
//  3. out_ready=0, 6 issues -> FIFO holds 4 and div_enable drops when the 5th reaches the tail.
//     Then set out_ready=1 -> all 6 drain in order with correct data; none lost or duplicated.
//  4. Full FIFO with tail valid, then out_ready=1 -> push and pop happen in the same cycle,
//     count stays 4, div_enable=1.
//  5. flush asserted with 3 in flight and 2 buffered -> next cycle out_valid=0, busy=0;
//     no stale result appears afterwards.
//  6. rst pulled low mid-stream with a pending issue -> all outputs at reset values immediately.
//     After release, a new op (tag 0x2A) completes alone with its correct result.

Source files
------------

// File: rtl/fp_div_writeback.sv
// Purpose: result-side controller for the enable-gated FP divider; shadows valid/tag through the divider pipe and buffers results.
// Latency: an issue accepted in cycle c presents out_valid in cycle c+LATENCY+1 when nothing stalls.
// Backpressure: a full FIFO with a valid tail freezes the divider and issue via div_enable; results are never dropped.
module fp_div_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int LATENCY    = 15,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [TAG_WIDTH-1:0]  issue_tag,
    output logic                  issue_ready,
    output logic                  div_enable,
    input  logic [DATA_WIDTH-1:0] div_res,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    input  logic                  out_ready,
    output logic                  busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [LATENCY-1:0]    stg_vld;
    logic [TAG_WIDTH-1:0]  stg_tag [LATENCY];
    logic                  tail_vld;
    logic [TAG_WIDTH-1:0]  tail_tag;

    logic [DATA_WIDTH-1:0] mem_dat [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;

    logic                  pop;
    logic                  push;
    logic                  can_push;

    assign tail_vld    = stg_vld[LATENCY-1];
    assign tail_tag    = stg_tag[LATENCY-1];

    assign out_valid   = (count != '0);
    assign pop         = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept the tail.
    assign can_push    = (count < CW'(FIFO_DEPTH)) || pop;
    assign div_enable  = !tail_vld || can_push;
    assign issue_ready = div_enable;
    assign push        = tail_vld && div_enable;

    assign out_data    = mem_dat[rd_ptr];
    assign out_tag     = mem_tag[rd_ptr];
    assign busy        = (|stg_vld) || out_valid;

    // Valid bits mirror the divider stages and only advance when the divider does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_vld <= '0;
        end else if (flush) begin
            stg_vld <= '0;
        end else if (div_enable) begin
            stg_vld[0] <= issue_valid;
            for (int i = 1; i < LATENCY; i++) begin
                stg_vld[i] <= stg_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (div_enable) begin
            stg_tag[0] <= issue_tag;
            for (int i = 1; i < LATENCY; i++) begin
                stg_tag[i] <= stg_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_dat[i] <= '0;
                mem_tag[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_dat[wr_ptr] <= div_res;
            mem_tag[wr_ptr] <= tail_tag;
        end
    end

    a_out_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data) && $stable(out_tag)));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_fp_div_writeback.sv
// Bench for fp_div_writeback: models the enable-gated divider, issues tagged ops and scoreboards results.
module tb_fp_div_writeback;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int LAT = 15;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          issue_valid = 1'b0;
    logic [TW-1:0] issue_tag = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] op0 = '0;
    logic [DW-1:0] op1 = '0;
    logic          issue_ready, div_enable, out_valid, busy;
    logic [DW-1:0] div_res, out_data;
    logic [TW-1:0] out_tag;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] dat;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_issue_cyc = 0;
    int   pop_cnt = 0;
    exp_t exp_q[$];
    int   pop_cyc_q[$];
    logic          hold_vld = 1'b0;
    logic [DW-1:0] hold_dat = '0;
    logic [TW-1:0] hold_tag = '0;
    logic [DW-1:0] last_dat = '0;
    logic [TW-1:0] last_tag = '0;
    logic          done = 1'b0;
    logic [DW-1:0] dpipe [LAT];

    fp_div_writeback #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
        .div_enable(div_enable), .div_res(div_res),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-precision divide done in double precision, quotient truncated back to single.
    function automatic logic [63:0] s2d(input logic [31:0] s);
        logic [10:0] e;
        e = 11'(s[30:23]) + 11'd896;
        return {s[31], e, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits($bitstoreal(s2d(a)) / $bitstoreal(s2d(b)));
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rnd_op();
        return {1'($urandom), 8'($urandom_range(134, 120)), 23'($urandom)};
    endfunction

    // Divider stand-in: operands enter every enabled edge, result emerges LAT enabled edges later.
    always @(posedge clk) begin
        if (div_enable) begin
            for (int i = LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
            dpipe[0] <= fdiv(op0, op1);
        end
    end
    assign div_res = dpipe[LAT-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every handshake pops the scoreboard; stalled heads must hold steady.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (hold_vld) begin
                checks++;
                if (!out_valid || out_data !== hold_dat || out_tag !== hold_tag) begin
                    errors++;
                    $display("FAIL out_stable: got vld %0b tag %0h dat %0h expected vld 1 tag %0h dat %0h",
                             out_valid, out_tag, out_data, hold_tag, hold_dat);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got tag %0h dat %0h expected no result", out_tag, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_tag !== e.tag || out_data !== e.dat) begin
                        errors++;
                        $display("FAIL out_order: got tag %0h dat %0h expected tag %0h dat %0h",
                                 out_tag, out_data, e.tag, e.dat);
                    end
                end
                pop_cnt++;
                pop_cyc_q.push_back(cyc);
                last_dat = out_data;
                last_tag = out_tag;
            end
            hold_vld = out_valid && !out_ready && !flush;
            hold_dat = out_data;
            hold_tag = out_tag;
        end else begin
            hold_vld = 1'b0;
        end
    end

    // Called just after a posedge; returns just after the posedge that took the op.
    task automatic issue(input logic [TW-1:0] tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n;
        n = 0;
        issue_valid = 1'b1;
        issue_tag   = tag;
        op0 = a;
        op1 = b;
        @(negedge clk);
        while (!issue_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!issue_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got issue_ready 0 expected 1 within 100 cycles");
        end else begin
            exp_q.push_back('{tag: tag, dat: fdiv(a, b)});
            last_issue_cyc = cyc;
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c, c0, n, p, seen;
        // Reset values
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_div_enable", div_enable, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single op latency and value
        out_ready = 1'b1;
        issue(8'h05, 32'h40C00000, 32'h40000000);
        c = last_issue_cyc;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("single_latency", cyc - c, LAT + 1);
        chk("single_data", out_data, 32'h40400000);
        chk("single_tag", out_tag, 8'h05);
        @(posedge clk);
        #1;
        drain();

        // Eight back-to-back issues with writeback always ready
        pop_cyc_q.delete();
        for (int i = 0; i < 8; i++) begin
            issue(8'(i), rnd_op(), rnd_op());
            if (i == 0) c0 = last_issue_cyc;
            chk("b2b_issue_cycle", last_issue_cyc - c0, i);
        end
        drain();
        chk("b2b_pop_count", pop_cyc_q.size(), 8);
        if (pop_cyc_q.size() == 8)
            chk("b2b_pop_span", pop_cyc_q[7] - pop_cyc_q[0], 7);

        // Writeback blocked: FIFO fills and the divider stalls on the fifth result
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue(8'(8'h10 + i), rnd_op(), rnd_op());
            if (i == 0) c0 = last_issue_cyc;
        end
        n = 0;
        @(negedge clk);
        while (div_enable && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("stall_cycle", cyc - c0, LAT + 4);
        chk("stall_issue_ready", issue_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_busy", busy, 1);
        // Release while full with the tail valid: push and pop together
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pushpop_enable", div_enable, 1);
        chk("full_pushpop_valid", out_valid, 1);
        @(negedge clk);
        chk("full_pushpop_enable2", div_enable, 1);
        @(posedge clk);
        #1;
        drain();

        // Randomised issue gaps and writeback backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    issue(8'(8'h40 + i), rnd_op(), rnd_op());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Flush with two buffered and three in flight
        out_ready = 1'b0;
        issue(8'hA0, rnd_op(), rnd_op());
        c = last_issue_cyc;
        issue(8'hA1, rnd_op(), rnd_op());
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        issue(8'hA2, rnd_op(), rnd_op());
        issue(8'hA3, rnd_op(), rnd_op());
        issue(8'hA4, rnd_op(), rnd_op());
        while (cyc < c + LAT + 2) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("preflush_out_valid", out_valid, 1);
        chk("preflush_busy", busy, 1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_stale", seen, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream with an issue pending
        issue(8'hB0, rnd_op(), rnd_op());
        issue(8'hB1, rnd_op(), rnd_op());
        issue_valid = 1'b1;
        issue_tag   = 8'h77;
        op0 = rnd_op();
        op1 = rnd_op();
        #3;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_out_tag", out_tag, 0);
        chk("arst_busy", busy, 0);
        chk("arst_issue_ready", issue_ready, 1);
        chk("arst_div_enable", div_enable, 1);
        exp_q.delete();
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        p = pop_cnt;
        issue(8'h2A, 32'h41200000, 32'h40A00000);
        drain();
        chk("arst_new_pops", pop_cnt - p, 1);
        chk("arst_new_tag", last_tag, 8'h2A);
        chk("arst_new_data", last_dat, 32'h40000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule
